// File: rtl/fifo_pkg.sv
// Shared defaults and state encoding for the FIFO read-side word packer.
package fifo_pkg;

    localparam int unsigned W_DEFAULT = 8;
    localparam int unsigned N_DEFAULT = 4;

    localparam int unsigned STATE_W = 1;
    localparam logic [STATE_W-1:0] ACC  = 1'b0;
    localparam logic [STATE_W-1:0] HOLD = 1'b1;

endpackage

// File: rtl/fifo_read_packer.sv
// Pulls W-bit entries from an external FIFO and packs N of them into one
// output word with valid/ready handshake. Partial-word flush support is
// compiled in with `define FIFO_PACKER_FLUSH_EN.
module fifo_read_packer
    import fifo_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT,
    parameter int unsigned N = N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           empty,
    input  logic [W-1:0]   d_in,
    output logic           r_en,
    input  logic           flush,
    output logic [N*W-1:0] m_data,
    output logic [N-1:0]   m_keep,
    output logic           m_last,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [15:0]    words_out
);

    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(N);
    localparam logic [CW:0]   FILL_MAX = (CW + 1)'(N);

    logic [STATE_W-1:0] state, state_d;
    logic [N*W-1:0]     acc, acc_d;
    logic [CW-1:0]      cnt, cnt_d;
    logic               pending;
    logic               hold_last, hold_last_d;

    logic [N*W-1:0]     m_data_d;
    logic [N-1:0]       m_keep_d;
    logic               m_last_d;
    logic               m_valid_d;
    logic [15:0]        words_out_d;

    logic [N*W-1:0]     asm_data;
    logic [CW-1:0]      asm_cnt;
    logic               out_free;
    logic               flush_now;
    logic               do_flush;
    logic               word_done;

`ifndef FIFO_PACKER_FLUSH_EN
    logic unused_flush;
    assign unused_flush = flush;
`endif

    // Lane-valid mask with the lowest c lanes set.
    function automatic logic [N-1:0] keep_of(input logic [CW-1:0] c);
        logic [N-1:0] k;
        k = '0;
        for (int i = 0; i < N; i++) begin
            k[i] = (CW'(i) < c);
        end
        return k;
    endfunction

    // Next-state, read strobe and output-register update.
    always_comb begin
        state_d     = state;
        acc_d       = acc;
        cnt_d       = cnt;
        hold_last_d = hold_last;
        m_data_d    = m_data;
        m_keep_d    = m_keep;
        m_last_d    = m_last;
        m_valid_d   = m_valid;
        words_out_d = words_out;

        // Word as it stands after any read landing this cycle.
        asm_data = acc;
        for (int i = 0; i < N; i++) begin
            if (pending && (cnt == CW'(i))) begin
                asm_data[i*W +: W] = d_in;
            end
        end
        asm_cnt = cnt + CW'(pending);

`ifdef FIFO_PACKER_FLUSH_EN
        flush_now = flush && (state == ACC) && ((cnt != '0) || pending);
        do_flush  = flush_now;
`else
        flush_now = 1'b0;
        do_flush  = 1'b0;
`endif

        out_free  = !m_valid || m_ready;
        word_done = (state == ACC) &&
                    ((asm_cnt == FULL_CNT) || (do_flush && (asm_cnt != '0)));

        r_en = rst_n && !empty && (state == ACC) && !flush_now &&
               (({1'b0, cnt} + (CW + 1)'(pending)) < FILL_MAX);

        if (m_valid && m_ready) begin
            m_valid_d   = 1'b0;
            words_out_d = words_out + 16'd1;
        end

        if (state == HOLD) begin
            if (out_free) begin
                m_data_d    = acc;
                m_keep_d    = keep_of(cnt);
                m_last_d    = hold_last;
                m_valid_d   = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
                hold_last_d = 1'b0;
                state_d     = ACC;
            end
        end else if (word_done) begin
            if (out_free) begin
                m_data_d  = asm_data;
                m_keep_d  = keep_of(asm_cnt);
                m_last_d  = do_flush;
                m_valid_d = 1'b1;
                acc_d     = '0;
                cnt_d     = '0;
            end else begin
                acc_d       = asm_data;
                cnt_d       = asm_cnt;
                hold_last_d = do_flush;
                state_d     = HOLD;
            end
        end else begin
            acc_d = asm_data;
            cnt_d = asm_cnt;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ACC;
            acc       <= '0;
            cnt       <= '0;
            pending   <= 1'b0;
            hold_last <= 1'b0;
            m_data    <= '0;
            m_keep    <= '0;
            m_last    <= 1'b0;
            m_valid   <= 1'b0;
            words_out <= '0;
        end else begin
            state     <= state_d;
            acc       <= acc_d;
            cnt       <= cnt_d;
            pending   <= r_en;
            hold_last <= hold_last_d;
            m_data    <= m_data_d;
            m_keep    <= m_keep_d;
            m_last    <= m_last_d;
            m_valid   <= m_valid_d;
            words_out <= words_out_d;
        end
    end

endmodule

// File: tb/tb_fifo_read_packer.sv
// Directed bench for fifo_read_packer with a behavioural FIFO model.
module tb_fifo_read_packer;

    localparam int unsigned W = 8;
    localparam int unsigned N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           empty;
    logic [W-1:0]   d_in = '0;
    logic           r_en;
    logic           flush;
    logic [N*W-1:0] m_data;
    logic [N-1:0]   m_keep;
    logic           m_last;
    logic           m_valid;
    logic           m_ready;
    logic [15:0]    words_out;

    logic [7:0] mem [0:255];
    int wr_ptr       = 0;
    int rd_ptr       = 0;
    int rd_count     = 0;
    int ren_viol     = 0;
    int valid_cycles = 0;

    logic [31:0] out_data [$];
    logic [3:0]  out_keep [$];
    logic        out_last [$];

    int n_vec = 0;
    int n_err = 0;

    fifo_read_packer #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .empty     (empty),
        .d_in      (d_in),
        .r_en      (r_en),
        .flush     (flush),
        .m_data    (m_data),
        .m_keep    (m_keep),
        .m_last    (m_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .words_out (words_out)
    );

    always #5 clk = ~clk;

    assign empty = (rd_ptr == wr_ptr);

    // FIFO model: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (r_en) begin
            d_in     <= mem[rd_ptr[7:0]];
            rd_ptr   <= rd_ptr + 1;
            rd_count <= rd_count + 1;
        end
    end

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (r_en && empty) ren_viol++;
        if (m_valid) valid_cycles++;
        if (m_valid && m_ready && rst_n) begin
            out_data.push_back(m_data);
            out_keep.push_back(m_keep);
            out_last.push_back(m_last);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[7:0]] = b;
        wr_ptr++;
    endtask

    task automatic clear_out();
        out_data.delete();
        out_keep.delete();
        out_last.delete();
    endtask

    task automatic wait_words(input string tag, input int n, input int budget);
        int t;
        t = 0;
        while (out_data.size() < n && t < budget) begin
            tick();
            t++;
        end
        check(tag, 64'(out_data.size()), 64'(n));
    endtask

    task automatic expect_word(input string tag, input logic [31:0] d,
                               input logic [3:0] k, input logic l);
        logic [31:0] gd;
        logic [3:0]  gk;
        logic        gl;
        gd = '1;
        gk = '1;
        gl = 1'bx;
        if (out_data.size() > 0) begin
            gd = out_data.pop_front();
            gk = out_keep.pop_front();
            gl = out_last.pop_front();
        end
        check({tag, "_data"}, 64'(gd), 64'(d));
        check({tag, "_keep"}, 64'(gk), 64'(k));
        check({tag, "_last"}, 64'(gl), 64'(l));
    endtask

    initial begin
        int rd0;
        int vc0;

        rst_n   = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        repeat (2) tick();
        check("rst_valid", 64'(m_valid), 64'd0);
        check("rst_ren",   64'(r_en),    64'd0);
        check("rst_data",  64'(m_data),  64'd0);
        check("rst_keep",  64'(m_keep),  64'd0);
        check("rst_last",  64'(m_last),  64'd0);
        check("rst_words", 64'(words_out), 64'd0);
        rst_n = 1'b1;
        tick();

        // Two full words streamed with downstream always ready.
        clear_out();
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(8'(i));
        wait_words("t1_count", 2, 60);
        expect_word("t1_w0", 32'h03020100, 4'b1111, 1'b0);
        expect_word("t1_w1", 32'h07060504, 4'b1111, 1'b0);
        repeat (2) tick();
        check("t1_words_out", 64'(words_out), 64'd2);

        // Downstream stall: reads stop once a second word is assembled.
        clear_out();
        m_ready = 1'b0;
        rd0 = rd_count;
        for (int i = 0; i < 12; i++) push(8'(i));
        repeat (20) tick();
        check("t2_reads",     64'(rd_count - rd0), 64'd8);
        check("t2_valid",     64'(m_valid),        64'd1);
        check("t2_hold_data", 64'(m_data),         64'h03020100);
        check("t2_ren_off",   64'(r_en),           64'd0);
        m_ready = 1'b1;
        wait_words("t2_count", 3, 60);
        expect_word("t2_w0", 32'h03020100, 4'b1111, 1'b0);
        expect_word("t2_w1", 32'h07060504, 4'b1111, 1'b0);
        expect_word("t2_w2", 32'h0B0A0908, 4'b1111, 1'b0);
        repeat (2) tick();
        check("t2_words_out", 64'(words_out), 64'd5);

        // FIFO runs dry mid-word; partial word waits without timeout.
        clear_out();
        vc0 = valid_cycles;
        push(8'h00);
        push(8'h01);
        repeat (15) tick();
        check("t3_gap_valid", 64'(valid_cycles - vc0), 64'd0);
        check("t3_gap_words", 64'(out_data.size()),   64'd0);
        push(8'h02);
        push(8'h03);
        wait_words("t3_count", 1, 30);
        expect_word("t3_w0", 32'h03020100, 4'b1111, 1'b0);
        repeat (2) tick();

        // Flush request with three lanes filled.
        clear_out();
        push(8'h08);
        push(8'h09);
        push(8'h0A);
        repeat (6) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
`ifdef FIFO_PACKER_FLUSH_EN
        wait_words("t4_count", 1, 10);
        expect_word("t4_flush", 32'h000A0908, 4'b0111, 1'b1);
`else
        repeat (8) tick();
        check("t4_no_flush", 64'(out_data.size()), 64'd0);
        push(8'h0B);
        wait_words("t4_count", 1, 20);
        expect_word("t4_full", 32'h0B0A0908, 4'b1111, 1'b0);
`endif
        repeat (2) tick();

        // Reset with a partial word discards it and clears outputs.
        clear_out();
        push(8'hA0);
        push(8'hA1);
        push(8'hA2);
        repeat (6) tick();
        rst_n = 1'b0;
        tick();
        check("t5_valid", 64'(m_valid),   64'd0);
        check("t5_ren",   64'(r_en),      64'd0);
        check("t5_data",  64'(m_data),    64'd0);
        check("t5_keep",  64'(m_keep),    64'd0);
        check("t5_last",  64'(m_last),    64'd0);
        check("t5_words", 64'(words_out), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
        wait_words("t5_count", 1, 30);
        expect_word("t5_w0", 32'h13121110, 4'b1111, 1'b0);
        repeat (2) tick();
        check("t5_words_out", 64'(words_out), 64'd1);

        check("ren_when_empty", 64'(ren_viol), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
